// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler.
// Optional feature macro: TICK_SCHED_ONESHOT_EN (per-channel one-shot mode).
package tick_sched_pkg;

    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned PRE_W_DEF = 16;
    localparam int unsigned PER_W_DEF = 16;

    typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

    // Per-channel architectural state
    typedef struct packed {
        ch_state_t              state;
`ifdef TICK_SCHED_ONESHOT_EN
        logic                   oneshot;
`endif
        logic [PER_W_DEF-1:0]   count;
        logic [PER_W_DEF-1:0]   period;
    } ch_reg_t;

    // A programmed period of 0 behaves as 1
    function automatic logic [PER_W_DEF-1:0] period_floor(input logic [PER_W_DEF-1:0] p);
        return (p == '0) ? PER_W_DEF'(1) : p;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: counts base ticks and emits a periodic event pulse.
// Optional feature macro: TICK_SCHED_ONESHOT_EN (stop after the first event).
module tick_channel
    import tick_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 wr_hit,
    input  logic                 wr_start,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic                 wr_oneshot,
`endif
    input  logic [PER_W_DEF-1:0] wr_period,
    output logic                 evt,
    output logic                 busy
);

    ch_reg_t              ch;
    logic [PER_W_DEF-1:0] count_nxt;

    assign count_nxt = ch.count + PER_W_DEF'(1);

    // Channel FSM: a write to this channel always wins over a same-cycle tick
    always_ff @(posedge clk) begin
        if (rst) begin
            ch  <= '0;
            evt <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (wr_hit) begin
                if (wr_start) begin
                    ch.state  <= CH_RUN;
                    ch.count  <= '0;
                    ch.period <= period_floor(wr_period);
`ifdef TICK_SCHED_ONESHOT_EN
                    ch.oneshot <= wr_oneshot;
`endif
                end else begin
                    ch.state <= CH_IDLE;
                end
            end else if ((ch.state == CH_RUN) && tick) begin
                if (count_nxt == ch.period) begin
                    ch.count <= '0;
                    evt      <= 1'b1;
`ifdef TICK_SCHED_ONESHOT_EN
                    if (ch.oneshot) begin
                        ch.state <= CH_IDLE;
                    end
`endif
                end else begin
                    ch.count <= count_nxt;
                end
            end
        end
    end

    // busy is a direct decode of the state flop
    assign busy = (ch.state == CH_RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: free-running prescaler producing a base tick, plus NCH
// channels that turn base ticks into periodic single-cycle event enables.
// Optional feature macro: TICK_SCHED_ONESHOT_EN (adds wr_oneshot input).
// Channel period storage width is PER_W_DEF from the package.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int unsigned NCH   = NCH_DEF,
    parameter  int unsigned PRE_W = PRE_W_DEF,
    parameter  int unsigned PER_W = PER_W_DEF,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PRE_W-1:0] prescale,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic             wr_start,
    input  logic [PER_W-1:0] wr_period,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic             wr_oneshot,
`endif
    output logic             wr_ack,
    output logic             tick,
    output logic [NCH-1:0]   evt,
    output logic [NCH-1:0]   busy
);

    logic [PRE_W-1:0]     pcnt;
    logic [PRE_W-1:0]     pre_last;
    logic [PER_W_DEF-1:0] period_in;

    // Terminal count is max(prescale,1)-1; compare with >= so a lowered
    // prescale takes effect immediately instead of wrapping
    assign pre_last  = (prescale == '0) ? '0 : prescale - PRE_W'(1);
    assign period_in = PER_W_DEF'(wr_period);

    // Free-running prescaler, never restarted by configuration writes
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt >= pre_last) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + PRE_W'(1);
            tick <= 1'b0;
        end
    end

    // Every write is acknowledged, including writes to absent channels
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_en;
        end
    end

    // Write decode and channel instances
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        tick_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .wr_hit     (wr_hit),
            .wr_start   (wr_start),
`ifdef TICK_SCHED_ONESHOT_EN
            .wr_oneshot (wr_oneshot),
`endif
            .wr_period  (period_in),
            .evt        (evt[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: the stimulus pushes expected outputs
// for specific cycles, the monitor compares them and flags any unexpected
// evt / wr_ack pulse. Define TICK_SCHED_ONESHOT_EN to exercise one-shot mode.
module tb_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic        wr_start;
    logic [15:0] wr_period;
    logic        wr_oneshot;
    logic        wr_ack;
    logic        tick;
    logic [3:0]  evt;
    logic [3:0]  busy;

    typedef struct {
        int         cyc;
        logic       tick;
        logic [3:0] evt;
        logic [3:0] busy;
        logic       ack;
    } rec_t;

    rec_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    tick_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_start   (wr_start),
        .wr_period  (wr_period),
`ifdef TICK_SCHED_ONESHOT_EN
        .wr_oneshot (wr_oneshot),
`endif
        .wr_ack     (wr_ack),
        .tick       (tick),
        .evt        (evt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic t, input logic [3:0] e,
                             input logic [3:0] b, input logic a);
        rec_t r;
        r.cyc = c; r.tick = t; r.evt = e; r.busy = b; r.ack = a;
        exp_q.push_back(r);
    endtask

    task automatic cmp(input string name, input int c, input logic [3:0] act,
                       input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, c, act, req);
        end
    endtask

    // Wait until the given cycle, landing 1 time unit after its rising edge
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic en, input int ch, input logic st, input logic [15:0] per);
        wr_en     = en;
        wr_ch     = 2'(ch);
        wr_start  = st;
        wr_period = per;
    endtask

    // Monitor: compare at scheduled cycles, reject pulses nobody expected
    always @(negedge clk) begin : mon
        rec_t r;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_record cyc=%0d actual=missed required=checked", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            r = exp_q.pop_front();
            cmp("tick",   cyc, {3'b0, tick},   {3'b0, r.tick});
            cmp("evt",    cyc, evt,            r.evt);
            cmp("busy",   cyc, busy,           r.busy);
            cmp("wr_ack", cyc, {3'b0, wr_ack}, {3'b0, r.ack});
        end else if (cyc > 0 && (wr_ack !== 1'b0 || evt !== 4'b0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d actual=evt:%b/ack:%b required=evt:0000/ack:0",
                     cyc, evt, wr_ack);
        end
    end

    initial begin
        rst = 1'b1; prescale = 16'd4; wr_oneshot = 1'b0;
        wr(1'b0, 0, 1'b0, 16'd0);

        // Reset state, then prescale=4 ticks, then prescale lowered to 2 at pcnt=2
        for (int c = 1; c <= 3; c++) expect_at(c, 1'b0, 4'b0, 4'b0, 1'b0);
        for (int c = 4; c <= 19; c++)
            expect_at(c, (c == 7 || c == 11 || c == 14 || c == 16 || c == 18), 4'b0, 4'b0, 1'b0);
        goto(3);  rst = 1'b0;
        goto(13); prescale = 16'd2;

        // Periodic ch0, period 3, prescale 4 (ticks at 22, 26, 30, ...)
        goto(19); prescale = 16'd4;
        expect_at(22, 1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_at(24, 1'b0, 4'b0000, 4'b0001, 1'b1);
        expect_at(26, 1'b1, 4'b0000, 4'b0001, 1'b0);
        expect_at(34, 1'b1, 4'b0000, 4'b0001, 1'b0);
        expect_at(35, 1'b0, 4'b0001, 4'b0001, 1'b0);
        expect_at(47, 1'b0, 4'b0001, 4'b0001, 1'b0);
        expect_at(59, 1'b0, 4'b0001, 4'b0001, 1'b0);
        expect_at(61, 1'b0, 4'b0000, 4'b0000, 1'b1);
        goto(23); wr(1'b1, 0, 1'b1, 16'd3);
        goto(24); wr(1'b0, 0, 1'b0, 16'd0);
        goto(60); wr(1'b1, 0, 1'b0, 16'd0);
        goto(61); wr(1'b0, 0, 1'b0, 16'd0);

        // Degenerate: prescale=0, ch1 period 0, then stop on a terminal tick
        goto(62);
        expect_at(62, 1'b1, 4'b0, 4'b0, 1'b0);
        expect_at(63, 1'b0, 4'b0, 4'b0, 1'b0);
        for (int c = 64; c <= 66; c++) expect_at(c, 1'b1, 4'b0, 4'b0, 1'b0);
        expect_at(67, 1'b1, 4'b0000, 4'b0010, 1'b1);
        for (int c = 68; c <= 75; c++) expect_at(c, 1'b1, 4'b0010, 4'b0010, 1'b0);
        expect_at(76, 1'b1, 4'b0000, 4'b0000, 1'b1);
        goto(63); prescale = 16'd0;
        goto(66); wr(1'b1, 1, 1'b1, 16'd0);
        goto(67); wr(1'b0, 0, 1'b0, 16'd0);
        goto(75); wr(1'b1, 1, 1'b0, 16'd0);
        goto(76); wr(1'b0, 0, 1'b0, 16'd0);

        // Collision: start ch2 in a tick cycle, stop it in its terminal-tick cycle
        goto(77); prescale = 16'd4;
        expect_at(77,  1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_at(78,  1'b0, 4'b0000, 4'b0000, 1'b0);
        expect_at(81,  1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_at(85,  1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_at(86,  1'b0, 4'b0000, 4'b0100, 1'b1);
        expect_at(89,  1'b1, 4'b0000, 4'b0100, 1'b0);
        expect_at(90,  1'b0, 4'b0000, 4'b0100, 1'b0);
        expect_at(93,  1'b1, 4'b0000, 4'b0100, 1'b0);
        expect_at(94,  1'b0, 4'b0100, 4'b0100, 1'b0);
        expect_at(101, 1'b1, 4'b0000, 4'b0100, 1'b0);
        expect_at(102, 1'b0, 4'b0000, 4'b0000, 1'b1);
        goto(85);  wr(1'b1, 2, 1'b1, 16'd2);
        goto(86);  wr(1'b0, 0, 1'b0, 16'd0);
        goto(101); wr(1'b1, 2, 1'b0, 16'd0);
        goto(102); wr(1'b0, 0, 1'b0, 16'd0);

        // All channels period 1, then reset with a write in flight
        goto(103);
        expect_at(104, 1'b0, 4'b0000, 4'b0001, 1'b1);
        expect_at(105, 1'b1, 4'b0000, 4'b0011, 1'b1);
        expect_at(106, 1'b0, 4'b0011, 4'b0111, 1'b1);
        expect_at(107, 1'b0, 4'b0000, 4'b1111, 1'b1);
        expect_at(109, 1'b1, 4'b0000, 4'b1111, 1'b0);
        expect_at(110, 1'b0, 4'b1111, 4'b1111, 1'b0);
        expect_at(111, 1'b0, 4'b0000, 4'b1111, 1'b0);
        for (int c = 112; c <= 125; c++)
            expect_at(c, (c == 116 || c == 120 || c == 124), 4'b0, 4'b0, 1'b0);
        wr(1'b1, 0, 1'b1, 16'd1);
        goto(104); wr(1'b1, 1, 1'b1, 16'd1);
        goto(105); wr(1'b1, 2, 1'b1, 16'd1);
        goto(106); wr(1'b1, 3, 1'b1, 16'd1);
        goto(107); wr(1'b0, 0, 1'b0, 16'd0);
        goto(111); rst = 1'b1; wr(1'b1, 0, 1'b1, 16'd5);
        goto(112); rst = 1'b0; wr(1'b0, 0, 1'b0, 16'd0);

`ifdef TICK_SCHED_ONESHOT_EN
        // One-shot ch3, period 2 (ticks at 128, 132, ...)
        goto(126);
        expect_at(127, 1'b0, 4'b0000, 4'b1000, 1'b1);
        expect_at(128, 1'b1, 4'b0000, 4'b1000, 1'b0);
        expect_at(132, 1'b1, 4'b0000, 4'b1000, 1'b0);
        expect_at(133, 1'b0, 4'b1000, 4'b0000, 1'b0);
        expect_at(136, 1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_at(140, 1'b1, 4'b0000, 4'b0000, 1'b0);
        wr(1'b1, 3, 1'b1, 16'd2); wr_oneshot = 1'b1;
        goto(127); wr(1'b0, 0, 1'b0, 16'd0); wr_oneshot = 1'b0;
`endif

        goto(245);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_records actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
